fetch_prefetch_unit: RTL and testbench
======================================

FETCH_PREFETCH_UNIT -- requirements
Module: fetch_prefetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, prefetch queue entries (power of two, 2..16).
REQ-002 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port mem_address  output  32  fetch address driven to the text memory bus.
REQ-005 SHALL have port mem_read_data  input  32  instruction word, valid the cycle after its mem_address.
REQ-006 SHALL have port redirect_valid  input  1  flush-and-restart request from branch/jump resolution.
REQ-007 SHALL have port redirect_pc  input  32  restart address, sampled when redirect_valid=1.
REQ-008 SHALL have port inst_valid  output  1  queue head holds an instruction for decode.
REQ-009 SHALL have port inst_ready  input  1  decode accepts the head this cycle.
REQ-010 SHALL have port inst_pc  output  32  address of the head instruction.
REQ-011 SHALL have port inst_word  output  32  head instruction word.
REQ-012 SHALL have port inst_fault  output  1  head address was misaligned or outside TEXT_BEGIN..TEXT_END.

Function
REQ-013 SHALL hold fetch_pc; mem_address SHALL equal fetch_pc combinationally.
REQ-014 SHALL issue a fetch in a cycle iff not halted, no redirect_valid, and (count + inflight) < DEPTH after this cycle's pop; on issue fetch_pc += 4 (32-bit wrap).
REQ-015 SHALL register each issue as inflight=1 with its pc; next cycle SHALL push {pc, mem_read_data, fault=0} into the queue.
REQ-016 SHALL treat an address with bits[1:0]!=0, below TEXT_BEGIN or above TEXT_END as faulting: no memory word used, entry pushed with word 32'h00000000 and fault=1.
REQ-017 SHALL enter halted state after issuing a faulting address; halted stops further issue until redirect.
REQ-018 SHALL present queue head on inst_* outputs; pop when inst_valid && inst_ready.
REQ-019 SHALL allow push and pop in the same cycle, including when full (count unchanged) and when empty (push only; no bypass, head visible next cycle).
REQ-020 SHALL hold inst_pc/inst_word/inst_fault stable while inst_valid=1 and inst_ready=0.
REQ-021 SHALL on redirect_valid=1: empty queue, drop any inflight response, clear halted, load fetch_pc=redirect_pc, issue nothing that cycle; inst_valid=0 next cycle.
REQ-022 SHALL give redirect priority over pop, push and issue in the same cycle.
REQ-023 SHALL give redirect-to-first-inst_valid latency of 3 cycles (redirect, issue, push) for an in-range target.
REQ-024 SHALL in steady state with inst_ready=1 deliver one instruction per cycle.

Reset
REQ-025 SHALL on reset set fetch_pc=TEXT_BEGIN, count=0, inflight=0, halted=0, queue pointers=0.
REQ-026 SHALL during and after reset drive inst_valid=0, inst_pc=0, inst_word=0, inst_fault=0.
REQ-027 SHALL on reset mid-operation discard queued and inflight data; no pre-reset instruction appears on inst_*.
REQ-028 SHALL issue the first fetch in the first cycle after reset deasserts.

Structure
REQ-029 SHALL take TEXT_BEGIN/TEXT_END from the shared config constants; fetch entry struct {pc, word, fault} SHALL live in a shared fetch package.
REQ-030 SHALL implement the queue as one sub-module, fetch_queue (DEPTH entries, push/pop, count, full/empty).
REQ-031 SHALL keep fault range check combinational on fetch_pc in the top module.

Verification (TEXT_BEGIN=0x00400000, TEXT_END=0x00400FFF, DEPTH=4)
REQ-032 SHALL: reset, inst_ready=1 -> inst_pc 0x00400000, 0x00400004, 0x00400008 on consecutive cycles, words match memory.
REQ-033 SHALL: inst_ready=0 for 10 cycles -> exactly 4 entries buffered, mem_address frozen at 0x00400010, head stable.
REQ-034 SHALL: redirect_pc=0x00400100 while full -> inst_valid=0 next cycle, first new inst_pc=0x00400100 three cycles after redirect, no stale pc delivered.
REQ-035 SHALL: redirect_pc=0x00400FFC, inst_ready=1 -> 0x00400FFC fault=0, then 0x00401000 fault=1 word=0, then no further issue.
REQ-036 SHALL: redirect_pc=0x00400102 -> single entry fault=1, halted until next redirect.
REQ-037 SHALL: reset asserted with 3 entries queued -> inst_valid=0 next cycle, restart at 0x00400000.

Source files
------------

// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared fetch definitions: text segment bounds, queue entry payload and fetch state.
package fetch_prefetch_unit_pkg;

  localparam logic [31:0] TEXT_BEGIN = 32'h0040_0000;
  localparam logic [31:0] TEXT_END   = 32'h0040_0FFF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
    logic        fault;
  } fetch_entry_t;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch queue of fetch entries; flush empties it, push and pop may coincide.
module fetch_queue
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetcher: issues sequential fetches into a small queue, flushes on redirect,
// and halts after issuing an address outside the text segment or misaligned.
module fetch_prefetch_unit
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_read_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_word,
  output logic        inst_fault
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             inflight_q;
  logic [31:0]      inflight_pc_q;
  logic             inflight_fault_q;

  logic             fault_c;
  logic             pop_c;
  logic             push_c;
  logic             issue_c;
  logic [OCC_W-1:0] occupancy_c;

  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  fetch_entry_t     push_data;
  fetch_entry_t     head_data;

  assign mem_address = fetch_pc_q;

  assign fault_c = (fetch_pc_q[1:0] != 2'b00) ||
                   (fetch_pc_q < TEXT_BEGIN)  ||
                   (fetch_pc_q > TEXT_END);

  // Redirect outranks every queue operation and any new issue.
  assign pop_c       = !empty && inst_ready && !redirect_valid;
  assign push_c      = inflight_q && !redirect_valid && (!full || pop_c);
  assign occupancy_c = OCC_W'(count) - OCC_W'(pop_c) + OCC_W'(inflight_q);
  assign issue_c     = (state_q == FETCH_RUN) && !redirect_valid &&
                       (occupancy_c < OCC_W'(DEPTH));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= FETCH_RUN;
      fetch_pc_q       <= TEXT_BEGIN;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= '0;
      inflight_fault_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      fetch_pc_q       <= fetch_pc_d;
      inflight_q       <= issue_c;
      inflight_pc_q    <= fetch_pc_q;
      inflight_fault_q <= fault_c;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      state_d    = FETCH_RUN;
      fetch_pc_d = redirect_pc;
    end else if (issue_c) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      if (fault_c) state_d = FETCH_HALT;
    end
  end

  // A faulting fetch never uses the bus word.
  always_comb begin
    push_data       = '0;
    push_data.pc    = inflight_pc_q;
    push_data.word  = inflight_fault_q ? 32'h0000_0000 : mem_read_data;
    push_data.fault = inflight_fault_q;
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push_c),
    .push_data (push_data),
    .pop       (pop_c),
    .head_data (head_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign inst_valid = !empty;
  assign inst_pc    = empty ? 32'h0 : head_data.pc;
  assign inst_word  = empty ? 32'h0 : head_data.word;
  assign inst_fault = empty ? 1'b0  : head_data.fault;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: table of redirect targets plus reset/stall sequences, scoreboard on pops.
module tb_fetch_prefetch_unit;

  logic        clock;
  logic        reset;
  logic [31:0] mem_address;
  logic [31:0] mem_read_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_word;
  logic        inst_fault;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
    logic        fault;
  } exp_t;

  typedef struct {
    logic [31:0] target;
    int          n;
    logic        halts;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[6];

  fetch_prefetch_unit #(.DEPTH(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .mem_address    (mem_address),
    .mem_read_data  (mem_read_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst_word      (inst_word),
    .inst_fault     (inst_fault)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic fault_of(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < 32'h0040_0000) || (a > 32'h0040_0FFF);
  endfunction

  // Text memory: word appears the cycle after its address.
  always @(posedge clock) mem_read_data <= word_of(mem_address);

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] start, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc    = start + 32'(4 * i);
      e.fault = fault_of(e.pc);
      e.word  = e.fault ? 32'h0 : word_of(e.pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    inst_ready = 1'b1;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    inst_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Scoreboard: every accepted head must match the oldest expected entry.
  always @(negedge clock) begin
    if (!reset && !redirect_valid && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got pc %08h expected none", inst_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check32("pop_pc", inst_pc, mon_e.pc);
        check32("pop_word", inst_word, mon_e.word);
        check32("pop_fault", {31'b0, inst_fault}, {31'b0, mon_e.fault});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    vecs[0] = '{target: 32'h0040_0100, n: 6, halts: 1'b0};
    vecs[1] = '{target: 32'h0040_0FFC, n: 2, halts: 1'b1};
    vecs[2] = '{target: 32'h0040_0102, n: 1, halts: 1'b1};
    vecs[3] = '{target: 32'h0040_0FF0, n: 5, halts: 1'b1};
    vecs[4] = '{target: 32'h003F_FFFC, n: 1, halts: 1'b1};
    vecs[5] = '{target: 32'h0040_0200, n: 4, halts: 1'b0};

    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check32("rst_valid", {31'b0, inst_valid}, 32'h0);
    check32("rst_pc", inst_pc, 32'h0);
    check32("rst_word", inst_word, 32'h0);
    check32("rst_fault", {31'b0, inst_fault}, 32'h0);
    check32("rst_addr", mem_address, 32'h0040_0000);

    // Sequential run from reset: first head two cycles after release, then one per cycle.
    tick();
    reset = 1'b0;
    inst_ready = 1'b1;
    push_exp(32'h0040_0000, 3);
    @(negedge clock); check32("boot_c0", {31'b0, inst_valid}, 32'h0);
    tick(); @(negedge clock); check32("boot_c1", {31'b0, inst_valid}, 32'h0);
    tick(); @(negedge clock); check32("boot_c2", {31'b0, inst_valid}, 32'h1);
    tick(); @(negedge clock); check32("boot_c3", {31'b0, inst_valid}, 32'h1);
    tick(); @(negedge clock); check32("boot_c4", {31'b0, inst_valid}, 32'h1);
    tick();
    drain("boot", 10);

    // Stall from reset: four fetches then frozen, head stable.
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    repeat (10) tick();
    @(negedge clock);
    check32("stall_addr", mem_address, 32'h0040_0010);
    check32("stall_valid", {31'b0, inst_valid}, 32'h1);
    check32("stall_pc", inst_pc, 32'h0040_0000);
    tick(); @(negedge clock);
    check32("stall_pc_hold", inst_pc, 32'h0040_0000);
    check32("stall_word_hold", inst_word, word_of(32'h0040_0000));
    check32("stall_addr_hold", mem_address, 32'h0040_0010);
    tick();
    push_exp(32'h0040_0000, 4);
    drain("stall", 20);
    repeat (6) tick();

    for (int v = 0; v < 6; v++) begin
      redirect_valid = 1'b1;
      redirect_pc = vecs[v].target;
      inst_ready = 1'b1;
      exp_q.delete();
      tick();
      redirect_valid = 1'b0;
      push_exp(vecs[v].target, vecs[v].n);
      @(negedge clock); check32("redir_flush", {31'b0, inst_valid}, 32'h0);
      tick(); @(negedge clock); check32("redir_c2", {31'b0, inst_valid}, 32'h0);
      tick(); @(negedge clock);
      check32("redir_c3_valid", {31'b0, inst_valid}, 32'h1);
      check32("redir_c3_pc", inst_pc, vecs[v].target);
      tick();
      drain("redir", 40);
      if (vecs[v].halts) begin
        inst_ready = 1'b1;
        a = mem_address;
        repeat (6) tick();
        @(negedge clock);
        check32("halt_addr", mem_address, a);
        check32("halt_valid", {31'b0, inst_valid}, 32'h0);
        tick();
        inst_ready = 1'b0;
      end else begin
        repeat (6) tick();
      end
    end

    // Reset with three entries queued: nothing old may surface afterwards.
    redirect_valid = 1'b1;
    redirect_pc = 32'h0040_0FF8;
    inst_ready = 1'b0;
    tick();
    redirect_valid = 1'b0;
    repeat (6) tick();
    @(negedge clock);
    check32("preq_valid", {31'b0, inst_valid}, 32'h1);
    check32("preq_pc", inst_pc, 32'h0040_0FF8);
    tick();
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    @(negedge clock);
    check32("mid_rst_valid", {31'b0, inst_valid}, 32'h0);
    check32("mid_rst_pc", inst_pc, 32'h0);
    check32("mid_rst_addr", mem_address, 32'h0040_0000);
    push_exp(32'h0040_0000, 3);
    drain("mid_rst", 20);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
